// File: rtl/multdiv.sv
// Sequential signed 32-bit multiply (radix-2 shift-add) and divide (restoring), 33 edges per op.
// Optional MULTDIV_EARLY_DIV0_EN: a divide by zero completes at the first edge after start.
module multdiv (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        fin_q, fin_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [31:0] res_q, res_d;
   logic        exc_q, exc_d;
   logic [63:0] work_q, work_d;

   logic        start, busy, fin_now, neg;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum, div_diff;
   logic [31:0] div_rem;
   logic [63:0] prod, mul_next, div_next;
   logic [31:0] quo;

   function automatic logic [31:0] mag(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fin_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         exc_q   <= 1'b0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fin_q   <= fin_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
         work_q  <= work_d;
      end
   end

   always_comb begin
      start = ctrl_MULT | ctrl_DIV;
      busy  = (state_q == MUL) || (state_q == DIV);
`ifdef MULTDIV_EARLY_DIV0_EN
      fin_now = fin_q || ((state_q == DIV) && (b_q == 32'd0));
`else
      fin_now = fin_q;
`endif
      mag_a = mag(a_q);
      mag_b = mag(b_q);
      neg   = a_q[31] ^ b_q[31];
      // work holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
      mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, mag_a} : 33'd0);
      mul_next = {mul_sum, work_q[31:1]};
      div_rem  = {work_q[62:32], work_q[31]};
      div_diff = {1'b0, div_rem} - {1'b0, mag_b};
      div_next = div_diff[32] ? {div_rem, work_q[30:0], 1'b0}
                              : {div_diff[31:0], work_q[30:0], 1'b1};
      prod = neg ? (~work_q + 64'd1) : work_q;
      quo  = neg ? (~work_q[31:0] + 32'd1) : work_q[31:0];
   end

   always_comb begin
      state_d = state_q;
      if (ctrl_MULT)     state_d = MUL;
      else if (ctrl_DIV) state_d = DIV;
      else begin
         case (state_q)
            MUL, DIV: if (fin_now) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = state_q;
         endcase
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      fin_d  = fin_q;
      a_d    = a_q;
      b_d    = b_q;
      res_d  = res_q;
      exc_d  = exc_q;
      work_d = work_q;
      if (start) begin
         a_d    = data_operandA;
         b_d    = data_operandB;
         cnt_d  = '0;
         fin_d  = 1'b0;
         work_d = {32'd0, mag(ctrl_MULT ? data_operandB : data_operandA)};
      end else if (busy) begin
         if (fin_now) begin
            fin_d = 1'b0;
            if (state_q == MUL) begin
               res_d = prod[31:0];
               exc_d = ~((&prod[63:31]) | ~(|prod[63:31]));
            end else if (b_q == 32'd0) begin
               res_d = 32'd0;
               exc_d = 1'b1;
            end else begin
               res_d = quo;
               exc_d = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
            end
         end else begin
            work_d = (state_q == MUL) ? mul_next : div_next;
            cnt_d  = cnt_q + 5'd1;
            fin_d  = (cnt_q == 5'd31);
         end
      end
   end

   always_comb begin
      data_result    = res_q;
      data_exception = exc_q;
      data_resultRDY = (state_q == DONE);
   end
endmodule
